conv_sequencer: RTL
===================

// Module: conv_sequencer
// PURPOSE
//  Top-level controller for one convolution pass. Sequences im2col, loads weights/im2col
//  rows into local buffers, streams rows into systolic_array, writes Y back to memory.
//  Arbitrates the single memory port between im2col (mem_sel=0) and itself (mem_sel=1).
//  Replaces the hand-written top-level state machine.
// PARAMETERS
//  M            12       rows streamed (IMG_H*IMG_W)
//  N            9        row length (FILTER_SIZE^2)
//  K            5        filter count / Y columns
//  DATA_WIDTH   32       word width
//  ADDR_WIDTH   32       memory address width
//  WEIGHT_BASE  0x1000   weight base, W word i at WEIGHT_BASE+i
//  IM2COL_BASE  0x2000   im2col base, X[m][n] at IM2COL_BASE+m*N+n
//  OUTPUT_BASE  0x3000   output base, Y[m][k] to OUTPUT_BASE+k*M+m
// PORTS
//  clk          in   1             clock, all logic on posedge
//  rst_n        in   1             async active-low reset
//  start        in   1             level; sampled only in IDLE
//  busy         out  1             high in every state except IDLE
//  done         out  1             one-cycle pulse at end of pass
//  im2col_rst   out  1             active-high reset to im2col
//  im2col_done  in   1             im2col finished (level)
//  sa_rst       out  1             active-high reset to systolic_array
//  sa_valid     in   1             Y valid strobe from array
//  sa_done      in   1             array finished (level)
//  X            out  DATA_WIDTH*N  row to array, word n at [n*DW+:DW]
//  W            out  DATA_WIDTH*N*K weight block, word i at [i*DW+:DW]
//  Y            in   DATA_WIDTH*K  result row, word k at [k*DW+:DW]
//  mem_sel      out  1             0: im2col owns mem port, 1: sequencer owns it
//  mem_addr     out  ADDR_WIDTH    sequencer address (read or write)
//  mem_rd_data  in   DATA_WIDTH    read data, 1-cycle latency after mem_addr
//  mem_wr_en    out  1             write strobe
//  mem_wr_data  out  DATA_WIDTH    write data
// BEHAVIOUR
//  Reset: state IDLE; im2col_rst=1, sa_rst=1; all other outputs 0; counters/buffers 0.
//  Mid-pass reset forces this immediately, no memory write completes afterwards.
//  IDLE: start=1 -> IM2COL. Clears Y buffer. start while busy is ignored.
//  IM2COL: im2col_rst=0, mem_sel=0. im2col_done=1 -> LOAD (im2col_rst=1 next cycle).
//  LOAD: mem_sel=1. Issues one read per cycle:
//   - addrs 0..N*K-1 at WEIGHT_BASE+i.
//   - then M*N addrs at IM2COL_BASE+j.
//   Data captured one cycle after issue. W updates word by word as captured.
//   Exit to RUN in the cycle after the last capture: N*K+M*N+1 cycles total (154 default).
//  RUN: sa_rst=0.
//   - Cycle r after entry (r<M): X=row r. X=0 for r>=M.
//   - Each sa_valid cycle stores Y in Y buffer slot y_cnt while y_cnt<M, then y_cnt++.
//   - Extra valids are dropped.
//   - sa_done=1 -> STORE, sa_rst=1. Unfilled slots stay 0.
//  STORE: mem_sel=1, mem_wr_en=1 for exactly K*M cycles (60 default), k-major order:
//   addr OUTPUT_BASE+k*M+m, data Y[m][k].
//  DONE: done=1 for one cycle, busy=1 -> IDLE. A new start is accepted in the cycle after.
//  mem_wr_en=0 outside STORE. mem_addr is don't-care when mem_sel=0.
//  Simultaneous im2col_done and sa_done: each is only looked at in its own state.
// TESTING
//  1 Reset: rst_n=0 mid-LOAD -> next edge state IDLE, im2col_rst=sa_rst=1,
//    busy=0, mem_wr_en=0.
//  2 Full pass, defaults: W[i]=i+1, X[m][n]=m*N+n, model array.
//    -> LOAD 154 cycles, mem_sel=1, then 60 writes to 0x3000..0x303B,
//    Y[m][k] at 0x3000+k*12+m, one done pulse.
//  3 Row stream: in RUN, X equals row 0..11 on cycles 0..11, then 0.
//    W holds 45 weight words from 0x1000..0x102C.
//  4 Arbitration: during IM2COL mem_sel=0, mem_wr_en=0.
//    mem_sel goes 1 in the cycle after im2col_done.
//  5 start held high across done -> second pass starts 1 cycle after done.
//    start pulses while busy -> ignored.
//  6 sa_valid for 14 cycles -> only first 12 rows written. 8 valids then sa_done
//    -> rows 8..11 written as 0.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer: top-level controller for one convolution pass.
// Runs im2col, loads weights and im2col rows into local buffers, streams
// rows into the systolic array, then writes the Y buffer back to memory.
// Owns the memory port (mem_sel=1) only while loading and storing.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for start, im2col/array held in reset
// S_IM2COL  | im2col running and owns the memory port
// S_LOAD    | one read per cycle: weights, then im2col rows
// S_RUN     | rows streamed to the array, Y rows captured on sa_valid
// S_STORE   | Y buffer written back, k-major, one word per cycle
// S_DONE    | one-cycle done pulse
module conv_sequencer #(
  parameter int M          = 12,
  parameter int N          = 9,
  parameter int K          = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 'h1000,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 'h3000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       im2col_rst,
  input  logic                       im2col_done,
  output logic                       sa_rst,
  input  logic                       sa_valid,
  input  logic                       sa_done,
  output logic [DATA_WIDTH*N-1:0]    X,
  output logic [DATA_WIDTH*N*K-1:0]  W,
  input  logic [DATA_WIDTH*K-1:0]    Y,
  output logic                       mem_sel,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data,
  output logic                       mem_wr_en,
  output logic [DATA_WIDTH-1:0]      mem_wr_data
);

  localparam int NW      = N * K;
  localparam int NX      = M * N;
  localparam int LD_LAST = NW + NX;          // final LOAD cycle index
  localparam int LCW     = $clog2(LD_LAST + 1);
  localparam int MCW     = $clog2(M + 1);
  localparam int KCW     = $clog2(K + 1);
  localparam int CCW     = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_IM2COL, S_LOAD, S_RUN, S_STORE, S_DONE
  } state_t;

  state_t                  state;
  logic [LCW-1:0]          ld_cnt;
  logic [MCW-1:0]          cap_r;
  logic [CCW-1:0]          cap_c;
  logic [MCW-1:0]          run_cnt;
  logic [MCW-1:0]          y_cnt;
  logic [MCW-1:0]          st_m;
  logic [KCW-1:0]          st_k;
  logic [DATA_WIDTH*N-1:0] xrow [M];
  logic [DATA_WIDTH*K-1:0] ybuf [M];

  logic [MCW-1:0]          run_nxt;
  logic [MCW-1:0]          st_m_nxt;
  logic [KCW-1:0]          st_k_nxt;
  logic [DATA_WIDTH*N-1:0] x_nxt;

  // Read address for LOAD slot j: weights first, im2col rows after.
  function automatic logic [ADDR_WIDTH-1:0] load_addr(input logic [LCW-1:0] j);
    if (j < LCW'(NW)) return WEIGHT_BASE + ADDR_WIDTH'(j);
    else              return IM2COL_BASE + ADDR_WIDTH'(j - LCW'(NW));
  endfunction

  // Next row to stream and next (m,k) position of the k-major write-back.
  always_comb begin
    run_nxt  = run_cnt + 1'b1;
    x_nxt    = '0;
    if (run_nxt < MCW'(M)) x_nxt = xrow[run_nxt];
    st_m_nxt = st_m + 1'b1;
    st_k_nxt = st_k;
    if (st_m == MCW'(M - 1)) begin
      st_m_nxt = '0;
      st_k_nxt = st_k + 1'b1;
    end
  end

  // Pass sequencer with registered outputs and local buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      im2col_rst  <= 1'b1;
      sa_rst      <= 1'b1;
      mem_sel     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      X           <= '0;
      W           <= '0;
      ld_cnt      <= '0;
      cap_r       <= '0;
      cap_c       <= '0;
      run_cnt     <= '0;
      y_cnt       <= '0;
      st_m        <= '0;
      st_k        <= '0;
      for (int i = 0; i < M; i++) begin
        xrow[i] <= '0;
        ybuf[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_IM2COL;
            busy       <= 1'b1;
            im2col_rst <= 1'b0;
            mem_sel    <= 1'b0;
            y_cnt      <= '0;
            for (int i = 0; i < M; i++) ybuf[i] <= '0;
          end
        end

        S_IM2COL: begin
          if (im2col_done) begin
            state      <= S_LOAD;
            im2col_rst <= 1'b1;
            mem_sel    <= 1'b1;
            mem_addr   <= WEIGHT_BASE;
            ld_cnt     <= '0;
            cap_r      <= '0;
            cap_c      <= '0;
          end
        end

        S_LOAD: begin
          // Data for the address issued in cycle ld_cnt-1 is on mem_rd_data now.
          if (ld_cnt != '0) begin
            if (ld_cnt <= LCW'(NW)) begin
              W[(ld_cnt - 1'b1) * DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
            end else begin
              xrow[cap_r][cap_c * DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
              if (cap_c == CCW'(N - 1)) begin
                cap_c <= '0;
                cap_r <= cap_r + 1'b1;
              end else begin
                cap_c <= cap_c + 1'b1;
              end
            end
          end
          if (ld_cnt == LCW'(LD_LAST)) begin
            state   <= S_RUN;
            mem_sel <= 1'b0;
            sa_rst  <= 1'b0;
            X       <= xrow[0];
            run_cnt <= '0;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt + 1'b1 < LCW'(LD_LAST)) mem_addr <= load_addr(ld_cnt + 1'b1);
          end
        end

        S_RUN: begin
          if (run_cnt < MCW'(M)) run_cnt <= run_nxt;
          X <= x_nxt;
          if (sa_valid && (y_cnt < MCW'(M))) begin
            ybuf[y_cnt] <= Y;
            y_cnt       <= y_cnt + 1'b1;
          end
          if (sa_done) begin
            state       <= S_STORE;
            sa_rst      <= 1'b1;
            X           <= '0;
            mem_sel     <= 1'b1;
            mem_wr_en   <= 1'b1;
            mem_addr    <= OUTPUT_BASE;
            st_m        <= '0;
            st_k        <= '0;
            // Slot 0 may be written on this same edge; forward it.
            mem_wr_data <= (sa_valid && (y_cnt == '0)) ? Y[0 +: DATA_WIDTH]
                                                       : ybuf[0][0 +: DATA_WIDTH];
          end
        end

        S_STORE: begin
          if ((st_k == KCW'(K - 1)) && (st_m == MCW'(M - 1))) begin
            state     <= S_DONE;
            mem_wr_en <= 1'b0;
            mem_sel   <= 1'b0;
            done      <= 1'b1;
          end else begin
            st_m        <= st_m_nxt;
            st_k        <= st_k_nxt;
            mem_addr    <= mem_addr + 1'b1;   // k*M+m is sequential in k-major order
            mem_wr_data <= ybuf[st_m_nxt][st_k_nxt * DATA_WIDTH +: DATA_WIDTH];
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
